relu_quant_maxpool2: RTL and testbench
======================================

Name: relu_quant_maxpool2

Overview:
- Stream stage directly downstream of conv_3x3. Consumes its raster-order 24-bit convolution results.
- Applies ReLU, then a right-shift requantize with saturation to 8 bits, then a 2x2 stride-2 max-pool.
- Emits 8-bit pooled pixels in raster order, ready to feed the next layer's conv_3x3 in_pixel.
- Stores one half-width line buffer of horizontal-pair maxima.

Parameters:
- IN_W, 24, input sample width; input is treated as signed two's complement.
- MAX_W, 256, maximum supported map_width; line buffer depth is MAX_W/2.
- DIM_W, 16, width of the map_width and map_height ports.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset).
- in_valid  input  1  in_pixel carries a conv result this cycle.
- in_pixel  input  IN_W  signed conv result, raster order.
- map_width  input  DIM_W  pixels per input row; legal range 2..MAX_W.
- map_height  input  DIM_W  rows per input frame; must be at least 1.
- shift  input  5  requantize right-shift amount, 0..23.
- out_valid  output  1  one-cycle strobe; out_pixel is valid.
- out_pixel  output  8  pooled, requantized pixel.
- frame_done  output  1  one-cycle pulse after the last input pixel of a frame.

Behaviour:
- Reset (rst=0 at a clk edge):
  - out_valid=0, out_pixel=0, frame_done=0.
  - Column and row counters =0; pipeline valid bits =0.
  - Line buffer contents are don't-care.
- Reset mid-frame discards the partial frame. The first accepted pixel after reset is (x=0, y=0).
- map_width, map_height and shift must be stable from the first pixel of a frame to its last. The block does not latch them.
- Only cycles with in_valid=1 advance state. Bubbles of any length are allowed anywhere, with no effect on results.
- Stage 1 (registered, 1 cycle):
  - r = (in_pixel<0) ? 0 : in_pixel.
  - q = r >>> shift (logical shift on the non-negative value).
  - q8 = (q>255) ? 255 : q[7:0].
  - Stage 1 also registers x parity, y parity, x>>1, and a flag "x < map_width rounded down to even".
- Stage 2 (registered, 1 cycle), acting on q8 at (x,y):
  - Even x: hold_reg <= q8.
  - Odd x: h = max(hold_reg, q8), unsigned compare.
    - Even y: linebuf[x>>1] <= h.
    - Odd y: out_pixel <= max(linebuf[x>>1], h) and out_valid <= 1.
- Latency: out_valid rises exactly 2 clk cycles after the edge that accepts the bottom-right pixel of a 2x2 window. out_valid is otherwise 0.
- Odd map_width: the last column is ignored. It is never written to hold_reg-pair logic and produces no output.
- Odd map_height: the last row writes the line buffer but never emits.
- Output count per frame = floor(W/2)*floor(H/2).
- Counters:
  - x increments per accepted pixel. At x==map_width-1, x wraps to 0 and y increments.
  - At x==map_width-1 and y==map_height-1, both wrap to 0.
  - frame_done is asserted 2 cycles after that accepting edge, aligned with the final out_valid if one exists.
- Line buffer read and write of the same index never conflict: writes occur only on even rows, reads only on odd rows.
- map_width outside 2..MAX_W is illegal; behaviour is undefined and not checked.

Test Plan:
- 4x4 map, in_pixel 1..16, shift=0:
  - Outputs exactly 6, 8, 14, 16, in that order.
  - First out_valid occurs 2 cycles after pixel 6 is accepted.
  - frame_done occurs 2 cycles after pixel 16, coincident with the output 16.
- ReLU: 2x2 map {-100, -5, -3, -1}, shift=0 -> single output 0.
  - Same map with {-100, -5, -3, 7} -> 7.
- Saturation and shift: 2x2 map {1000, 4, 4, 4}, shift=2 -> 250. {2000, 0, 0, 0}, shift=2 -> 255.
- Odd dimensions: 5x5 map, values 1..25, shift=0:
  - Outputs 7, 9, 17, 19 only.
  - frame_done occurs 2 cycles after pixel 25, with no out_valid on that cycle.
- Bubbles: repeat the 4x4 case with in_valid low on every other cycle, plus a 10-cycle gap mid-row 2. Outputs are again 6, 8, 14, 16.
- Reset mid-frame: feed 6 pixels of a 4x4 frame, hold rst=0 for 2 cycles, then feed a full 4x4 frame of 1..16.
  - Exactly 4 outputs: 6, 8, 14, 16.
  - No output occurs during or before reset release.
- Back-to-back frames: two 4x4 frames with no gap. Output is 6, 8, 14, 16, 6, 8, 14, 16, with two frame_done pulses.

Source files
------------

// File: rtl/relu_quant_maxpool2.sv
// ReLU + shift requantize to 8 bits + 2x2 stride-2 max-pool on a raster stream.
// Two register stages: requantize/position capture, then pair/line-buffer pooling.
module relu_quant_maxpool2 #(
    parameter int IN_W  = 24,
    parameter int MAX_W = 256,
    parameter int DIM_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_pixel,
    input  logic [DIM_W-1:0] map_width,
    input  logic [DIM_W-1:0] map_height,
    input  logic [4:0]       shift,
    output logic             out_valid,
    output logic [7:0]       out_pixel,
    output logic             frame_done
);

    localparam int LB_DEPTH = MAX_W / 2;
    localparam int XH_W     = $clog2(LB_DEPTH);

    logic [DIM_W-1:0] x_cnt;
    logic [DIM_W-1:0] y_cnt;
    logic             x_last;
    logic             y_last;
    logic             x_in_pair;
    logic [IN_W-2:0]  relu_mag;
    logic [IN_W-2:0]  shifted;
    logic [7:0]       q8;

    always_comb begin
        x_last    = (x_cnt == map_width - DIM_W'(1));
        y_last    = (y_cnt == map_height - DIM_W'(1));
        // an odd width leaves its last column outside every 2x2 window
        x_in_pair = (x_cnt < {map_width[DIM_W-1:1], 1'b0});
        relu_mag  = in_pixel[IN_W-1] ? '0 : in_pixel[IN_W-2:0];
        shifted   = relu_mag >> shift;
        q8        = (|shifted[IN_W-2:8]) ? 8'hFF : shifted[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (in_valid) begin
            if (x_last) begin
                x_cnt <= '0;
                y_cnt <= y_last ? '0 : y_cnt + DIM_W'(1);
            end else begin
                x_cnt <= x_cnt + DIM_W'(1);
            end
        end
    end

    logic            s1_valid;
    logic [7:0]      s1_q8;
    logic            s1_x_odd;
    logic            s1_y_odd;
    logic [XH_W-1:0] s1_xh;
    logic            s1_pair;
    logic            s1_last;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_q8    <= '0;
            s1_x_odd <= 1'b0;
            s1_y_odd <= 1'b0;
            s1_xh    <= '0;
            s1_pair  <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            s1_last  <= in_valid & x_last & y_last;
            if (in_valid) begin
                s1_q8    <= q8;
                s1_x_odd <= x_cnt[0];
                s1_y_odd <= y_cnt[0];
                s1_xh    <= x_cnt[XH_W:1];
                s1_pair  <= x_in_pair;
            end
        end
    end

    logic [7:0] hold_reg;
    logic [7:0] line_buf [LB_DEPTH];
    logic [7:0] lb_rd;
    logic [7:0] h_max;
    logic [7:0] v_max;
    logic       pair_done;

    always_comb begin
        lb_rd     = line_buf[s1_xh];
        h_max     = (s1_q8 > hold_reg) ? s1_q8 : hold_reg;
        v_max     = (lb_rd > h_max) ? lb_rd : h_max;
        pair_done = s1_valid & s1_pair & s1_x_odd;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_reg   <= '0;
            out_valid  <= 1'b0;
            out_pixel  <= '0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= pair_done & s1_y_odd;
            frame_done <= s1_last;
            if (s1_valid && s1_pair && !s1_x_odd) begin
                hold_reg <= s1_q8;
            end
            if (pair_done && s1_y_odd) begin
                out_pixel <= v_max;
            end
        end
    end

    // even rows only write, odd rows only read, so one port pair never collides
    always_ff @(posedge clk) begin
        if (pair_done && !s1_y_odd) begin
            line_buf[s1_xh] <= h_max;
        end
    end

endmodule

// File: tb/tb_relu_quant_maxpool2.sv
// Bench for relu_quant_maxpool2: directed frames plus randomized frames vs. a 2-D array model.
module tb_relu_quant_maxpool2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [23:0] in_pixel = '0;
    logic [15:0] map_width = 16'd4;
    logic [15:0] map_height = 16'd4;
    logic [4:0]  shift = '0;
    logic        out_valid;
    logic [7:0]  out_pixel;
    logic        frame_done;

    relu_quant_maxpool2 #(.IN_W(24), .MAX_W(256), .DIM_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_pixel   (in_pixel),
        .map_width  (map_width),
        .map_height (map_height),
        .shift      (shift),
        .out_valid  (out_valid),
        .out_pixel  (out_pixel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_bad = 0;
    int n_done = 0;
    int exp_val[$];
    int exp_t[$];
    int done_t[$];
    int obs[$];
    int lit[$];
    int fp[0:1023];

    task automatic chk(input string tag, input int got, input int want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            obs.push_back(int'(out_pixel));
            if (exp_val.size() == 0) chk("unexpected_out", int'(out_pixel) + 1000, 0);
            else begin
                chk("out_pixel", int'(out_pixel), exp_val.pop_front());
                chk("out_time", cyc, exp_t.pop_front());
            end
        end
        if (frame_done === 1'b1) begin
            n_done++;
            if (done_t.size() == 0) chk("unexpected_done", 1, 0);
            else chk("done_time", cyc, done_t.pop_front());
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    function automatic int rq(input int v, input int sh);
        int q;
        if (v < 0) return 0;
        q = v >>> sh;
        return (q > 255) ? 255 : q;
    endfunction

    function automatic int mx(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pix(input int v);
        in_valid = 1'b1;
        in_pixel = 24'(v);
        tick();
        in_valid = 1'b0;
    endtask

    // mode 0: dense, 1: every other cycle + 10-cycle gap in row 2, 2: random gaps
    task automatic run_frame(input int w, input int h, input int sh, input int mode,
                             input int n_feed, input int track);
        int x, y, win;
        map_width  = 16'(w);
        map_height = 16'(h);
        shift      = 5'(sh);
        for (int idx = 0; idx < n_feed; idx++) begin
            x = idx % w;
            y = idx / w;
            if (mode == 1 && idx > 0) tick();
            if (mode == 1 && idx == 2 * w + w / 2) repeat (10) tick();
            if (mode == 2) repeat ($urandom_range(0, 2)) tick();
            if (track != 0) begin
                if ((x % 2 == 1) && (y % 2 == 1) && (x < (w / 2) * 2)) begin
                    win = mx(mx(rq(fp[(y-1)*w + x-1], sh), rq(fp[(y-1)*w + x], sh)),
                             mx(rq(fp[y*w + x-1], sh), rq(fp[idx], sh)));
                    exp_val.push_back(win);
                    exp_t.push_back(cyc + 2);
                end
                if (idx == w * h - 1) done_t.push_back(cyc + 2);
            end
            push_pix(fp[idx]);
        end
    endtask

    task automatic fill_seq(input int n);
        for (int i = 0; i < n; i++) fp[i] = i + 1;
    endtask

    task automatic check_seq(input string tag);
        chk({tag, "_count"}, obs.size(), lit.size());
        for (int i = 0; i < obs.size() && i < lit.size(); i++) chk(tag, obs[i], lit[i]);
        obs.delete();
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_pixel", int'(out_pixel), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        rst = 1'b1;
        tick();

        fill_seq(16);
        n_done = 0;
        run_frame(4, 4, 0, 0, 16, 1);
        repeat (4) tick();
        lit = '{6, 8, 14, 16};
        check_seq("seq_4x4");
        chk("done_4x4", n_done, 1);

        fp[0] = -100; fp[1] = -5; fp[2] = -3; fp[3] = -1;
        run_frame(2, 2, 0, 0, 4, 1);
        repeat (4) tick();
        lit = '{0};
        check_seq("relu_neg");
        fp[3] = 7;
        run_frame(2, 2, 0, 0, 4, 1);
        repeat (4) tick();
        lit = '{7};
        check_seq("relu_pos");

        fp[0] = 1000; fp[1] = 4; fp[2] = 4; fp[3] = 4;
        run_frame(2, 2, 2, 0, 4, 1);
        repeat (4) tick();
        lit = '{250};
        check_seq("shift2");
        fp[0] = 2000; fp[1] = 0; fp[2] = 0; fp[3] = 0;
        run_frame(2, 2, 2, 0, 4, 1);
        repeat (4) tick();
        lit = '{255};
        check_seq("saturate");

        fill_seq(25);
        n_done = 0;
        run_frame(5, 5, 0, 0, 25, 1);
        repeat (4) tick();
        lit = '{7, 9, 17, 19};
        check_seq("odd_5x5");
        chk("done_5x5", n_done, 1);

        fill_seq(16);
        run_frame(4, 4, 0, 1, 16, 1);
        repeat (4) tick();
        lit = '{6, 8, 14, 16};
        check_seq("bubbles");

        n_done = 0;
        run_frame(4, 4, 0, 0, 6, 0);
        rst = 1'b0;
        tick();
        tick();
        chk("midrst_out_valid", int'(out_valid), 0);
        rst = 1'b1;
        run_frame(4, 4, 0, 0, 16, 1);
        repeat (4) tick();
        lit = '{6, 8, 14, 16};
        check_seq("midrst");
        chk("done_midrst", n_done, 1);

        n_done = 0;
        run_frame(4, 4, 0, 0, 16, 1);
        run_frame(4, 4, 0, 0, 16, 1);
        repeat (4) tick();
        lit = '{6, 8, 14, 16, 6, 8, 14, 16};
        check_seq("b2b");
        chk("done_b2b", n_done, 2);

        for (int it = 0; it < 24; it++) begin
            int w, h, sh, big;
            w   = int'($urandom_range(2, 12));
            h   = int'($urandom_range(1, 9));
            big = (($urandom_range(0, 3)) == 0) ? 1 : 0;
            sh  = big != 0 ? int'($urandom_range(0, 23)) : int'($urandom_range(0, 3));
            for (int i = 0; i < w * h; i++) begin
                if (big != 0) fp[i] = int'($urandom_range(0, 16777215)) - 8388608;
                else fp[i] = int'($urandom_range(0, 1500)) - 400;
            end
            run_frame(w, h, sh, (it % 3 == 0) ? 0 : 2, w * h, 1);
            if (it % 4 == 3) repeat (3) tick();
        end

        for (int i = 0; i < 256 * 3; i++) fp[i] = int'($urandom_range(0, 700)) - 100;
        run_frame(256, 3, 1, 0, 256 * 3, 1);
        repeat (5) tick();
        obs.delete();

        chk("leftover_out", exp_val.size(), 0);
        chk("leftover_done", done_t.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
